mem_req_ctrl: RTL and testbench
===============================

MEM_REQ_CTRL -- requirements
Module: mem_req_ctrl

Interface
REQ-001 SHALL have port clk_i, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port resetn_i, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port mem_valid_i, input, 1 bit: the MEM-stage instruction is a load or store.
REQ-004 SHALL have port mem_wr_i, input, 1 bit: 1 = store, 0 = load.
REQ-005 SHALL have port mem_size_i, input, 2 bits: 0 = byte, 1 = half, 2 = word; 3 is reserved.
REQ-006 SHALL have port load_sign_i, input, 1 bit: 1 = sign-extend load result, 0 = zero-extend.
REQ-007 SHALL have port addr_i, input, 32 bits: effective address.
REQ-008 SHALL have port store_data_i, input, 32 bits: store data, right-aligned.
REQ-009 SHALL have port advance_i, input, 1 bit: pipeline advances this cycle (no IF, EX or MEM stall).
REQ-010 SHALL have port flush_i, input, 1 bit: exception flush of the MEM-stage instruction.
REQ-011 SHALL have port mem_stall_o, output, 1 bit: MEM stage must hold.
REQ-012 SHALL have port load_data_o, output, 32 bits: aligned and extended load result.
REQ-013 SHALL have port addr_err_o, output, 1 bit: misaligned access detected.
REQ-014 SHALL have bus ports data_req_o, data_wr_o, data_size_o[1:0], data_addr_o[31:0], data_wdata_o[31:0] (outputs) and data_addr_ok_i, data_data_ok_i, data_rdata_i[31:0] (inputs), forming an SRAM-like handshake.

Function
REQ-015 SHALL implement a four-state FSM: IDLE, ADDR, DATA, DONE.
REQ-016 SHALL define the internal signal access = mem_valid_i & ~flush_i & ~addr_err_o.
REQ-017 SHALL drive addr_err_o combinationally, in IDLE only, when mem_valid_i is high and either (size = half and addr_i[0] = 1) or (size = word and addr_i[1:0] != 0); in that case no request is issued and no stall is raised.
REQ-018 SHALL, in IDLE with access high, assert data_req_o combinationally in the same cycle; the next state is DATA if data_addr_ok_i is high, otherwise ADDR.
REQ-019 SHALL register mem_wr_i, mem_size_i, load_sign_i, addr_i and the store data on issue, and drive the bus from those registers in ADDR.
REQ-020 SHALL, in ADDR, hold data_req_o high with stable bus fields until data_addr_ok_i, then go to DATA; flush_i is ignored in ADDR.
REQ-021 SHALL, in DATA, on data_data_ok_i: register the formatted load result (loads only) and go to DONE; data_data_ok_i is ignored in every state other than DATA.
REQ-022 SHALL go from DONE to IDLE when advance_i or flush_i is high; a new access is evaluated only in IDLE, on the following cycle.
REQ-023 SHALL drive mem_stall_o = (IDLE & access) | ADDR | DATA, so it is deasserted in DONE and in IDLE with no access.
REQ-024 SHALL, in DATA with flush_i high, still complete the transaction and discard the result (DONE is skipped: DATA goes to IDLE on data_data_ok_i).
REQ-025 SHALL replicate store data on data_wdata_o by size: byte as {4{sd[7:0]}}, half as {2{sd[15:0]}}, word unchanged.
REQ-026 SHALL format load data as follows: select the byte/half lane using the registered addr[1:0], then sign- or zero-extend to 32 bits; a word passes unchanged.
REQ-027 SHALL give a minimum load latency of 2 cycles: addr_ok at cycle 0, data_ok at cycle 1, stall low and data valid at cycle 2.
REQ-028 SHALL hold load_data_o stable from DONE entry until the next load completes.

Reset
REQ-029 SHALL, on resetn_i low, go to IDLE with data_req_o = 0, mem_stall_o = 0 and load_data_o = 0, regardless of current state; any outstanding bus transaction is abandoned.

Structure
REQ-030 SHALL place the size encodings (BYTE/HALF/WORD) and the FSM state encoding in the shared CPU package.
REQ-031 SHALL put load formatting in a combinational sub-module named load_align (inputs: rdata, addr[1:0], size, sign; output: 32-bit result).

Verification
REQ-032 SHALL cover: lw at addr 0x100, addr_ok immediate, data_ok next cycle, rdata 0xDEADBEEF -> stall high for 2 cycles, then load_data_o = 0xDEADBEEF.
REQ-033 SHALL cover: lb signed at addr 0x103, rdata 0x80FF_FF7F -> load_data_o = 0xFFFFFF80; the same access as lbu -> 0x00000080.
REQ-034 SHALL cover: sh at addr 0x102 with store_data 0x1234ABCD and addr_ok delayed 3 cycles -> data_req_o held 4 cycles with data_wdata_o = 0xABCDABCD, stable throughout.
REQ-035 SHALL cover: lw at addr 0x101 -> addr_err_o = 1, data_req_o = 0, mem_stall_o = 0.
REQ-036 SHALL cover: load completes while advance_i is low for 3 cycles -> state stays DONE, no re-issue, mem_stall_o = 0, load_data_o held.
REQ-037 SHALL cover: resetn_i driven low while in DATA -> immediately IDLE, data_req_o = 0, load_data_o = 0.

Source files
------------

// File: rtl/mem_req_ctrl_pkg.sv
// Shared CPU definitions for the MEM-stage data-bus controller: access size
// encodings, controller state encoding and small alignment helpers.
package mem_req_ctrl_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Halves need an even address, words need a 4-byte-aligned one.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    return ((size == SIZE_HALF) && addr_lo[0]) ||
           ((size == SIZE_WORD) && (addr_lo != 2'b00));
  endfunction

  function automatic logic [31:0] replicate_wdata(input logic [1:0] size, input logic [31:0] sd);
    logic [31:0] res;
    case (size)
      SIZE_BYTE: res = {4{sd[7:0]}};
      SIZE_HALF: res = {2{sd[15:0]}};
      default:   res = sd;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_req_ctrl_load_align.sv
// Load formatting: picks the byte/half lane addressed by addr[1:0] out of the
// bus read word and sign- or zero-extends it to 32 bits.
module load_align
  import mem_req_ctrl_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[7:0];
    case (addr_i)
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      2'd3:    byte_sel = rdata_i[31:24];
      default: byte_sel = rdata_i[7:0];
    endcase
    half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (size_i)
      SIZE_BYTE: result_o = {{24{sign_i & byte_sel[7]}}, byte_sel};
      SIZE_HALF: result_o = {{16{sign_i & half_sel[15]}}, half_sel};
      default:   result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_req_ctrl.sv
// MEM-stage load/store controller: issues one SRAM-like bus transaction per
// access, stalls the pipeline until the data phase ends and formats loads.
module mem_req_ctrl
  import mem_req_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        resetn_i,
  input  logic        mem_valid_i,
  input  logic        mem_wr_i,
  input  logic [1:0]  mem_size_i,
  input  logic        load_sign_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] store_data_i,
  input  logic        advance_i,
  input  logic        flush_i,
  output logic        mem_stall_o,
  output logic [31:0] load_data_o,
  output logic        addr_err_o,
  output logic        data_req_o,
  output logic        data_wr_o,
  output logic [1:0]  data_size_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_addr_ok_i,
  input  logic        data_data_ok_i,
  input  logic [31:0] data_rdata_i
);

  state_e      state_q, state_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic        sign_q, sign_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] load_data_q, load_data_d;
  logic        kill_q, kill_d;
  logic        access;
  logic [31:0] fmt_data;

  assign addr_err_o  = (state_q == ST_IDLE) & mem_valid_i & misaligned(mem_size_i, addr_i[1:0]);
  // Gating with resetn_i keeps the bus request quiet while reset is held.
  assign access      = resetn_i & mem_valid_i & ~flush_i & ~addr_err_o;
  assign load_data_o = load_data_q;

  load_align u_load_align (
    .rdata_i  (data_rdata_i),
    .addr_i   (addr_q[1:0]),
    .size_i   (size_q),
    .sign_i   (sign_q),
    .result_o (fmt_data)
  );

  always_comb begin
    state_d      = state_q;
    wr_d         = wr_q;
    size_d       = size_q;
    sign_d       = sign_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    load_data_d  = load_data_q;
    kill_d       = kill_q;
    data_req_o   = 1'b0;
    mem_stall_o  = 1'b0;
    data_wr_o    = wr_q;
    data_size_o  = size_q;
    data_addr_o  = addr_q;
    data_wdata_o = wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (access) begin
          data_req_o   = 1'b1;
          mem_stall_o  = 1'b1;
          data_wr_o    = mem_wr_i;
          data_size_o  = mem_size_i;
          data_addr_o  = addr_i;
          data_wdata_o = replicate_wdata(mem_size_i, store_data_i);
          wr_d         = mem_wr_i;
          size_d       = mem_size_i;
          sign_d       = load_sign_i;
          addr_d       = addr_i;
          wdata_d      = replicate_wdata(mem_size_i, store_data_i);
          kill_d       = 1'b0;
          state_d      = data_addr_ok_i ? ST_DATA : ST_ADDR;
        end
      end
      ST_ADDR: begin
        data_req_o  = 1'b1;
        mem_stall_o = 1'b1;
        if (data_addr_ok_i) state_d = ST_DATA;
      end
      ST_DATA: begin
        // A flush seen in any data cycle drops the result but the bus
        // transaction must still be allowed to finish.
        mem_stall_o = 1'b1;
        if (flush_i) kill_d = 1'b1;
        if (data_data_ok_i) begin
          if (flush_i | kill_q) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DONE;
            if (!wr_q) load_data_d = fmt_data;
          end
        end
      end
      ST_DONE: begin
        if (advance_i | flush_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q     <= ST_IDLE;
      wr_q        <= 1'b0;
      size_q      <= SIZE_BYTE;
      sign_q      <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      load_data_q <= 32'h0;
      kill_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      size_q      <= size_d;
      sign_q      <= sign_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      load_data_q <= load_data_d;
      kill_q      <= kill_d;
    end
  end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl: a vector table for the idle-state issue
// decision plus hand-written multi-cycle load/store/flush/reset sequences.
module tb_mem_req_ctrl;
  import mem_req_ctrl_pkg::*;

  logic        clk_i = 1'b0;
  logic        resetn_i;
  logic        mem_valid_i, mem_wr_i, load_sign_i, advance_i, flush_i;
  logic [1:0]  mem_size_i;
  logic [31:0] addr_i, store_data_i;
  logic        mem_stall_o, addr_err_o;
  logic [31:0] load_data_o;
  logic        data_req_o, data_wr_o;
  logic [1:0]  data_size_o;
  logic [31:0] data_addr_o, data_wdata_o;
  logic        data_addr_ok_i, data_data_ok_i;
  logic [31:0] data_rdata_i;

  int checks = 0;
  int errors = 0;

  mem_req_ctrl dut (
    .clk_i          (clk_i),
    .resetn_i       (resetn_i),
    .mem_valid_i    (mem_valid_i),
    .mem_wr_i       (mem_wr_i),
    .mem_size_i     (mem_size_i),
    .load_sign_i    (load_sign_i),
    .addr_i         (addr_i),
    .store_data_i   (store_data_i),
    .advance_i      (advance_i),
    .flush_i        (flush_i),
    .mem_stall_o    (mem_stall_o),
    .load_data_o    (load_data_o),
    .addr_err_o     (addr_err_o),
    .data_req_o     (data_req_o),
    .data_wr_o      (data_wr_o),
    .data_size_o    (data_size_o),
    .data_addr_o    (data_addr_o),
    .data_wdata_o   (data_wdata_o),
    .data_addr_ok_i (data_addr_ok_i),
    .data_data_ok_i (data_data_ok_i),
    .data_rdata_i   (data_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        valid;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] sd;
    logic        flush;
    logic        expReq;
    logic        expStall;
    logic        expErr;
    logic [31:0] expWdata;
  } vec_t;

  vec_t vecs[12];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    mem_valid_i  = v.valid;
    mem_wr_i     = v.wr;
    mem_size_i   = v.size;
    addr_i       = v.addr;
    store_data_i = v.sd;
    flush_i      = v.flush;
    load_sign_i  = 1'b0;
  endtask

  task automatic idleInputs();
    mem_valid_i    = 1'b0;
    mem_wr_i       = 1'b0;
    mem_size_i     = SIZE_BYTE;
    load_sign_i    = 1'b0;
    addr_i         = 32'h0;
    store_data_i   = 32'h0;
    advance_i      = 1'b0;
    flush_i        = 1'b0;
    data_addr_ok_i = 1'b0;
    data_data_ok_i = 1'b0;
    data_rdata_i   = 32'h0;
  endtask

  // Zero-wait load: addr_ok in the issue cycle, data_ok in the next one.
  task automatic runLoad(input logic [31:0] addr, input logic [1:0] size, input logic sign,
                         input logic [31:0] rdata, output logic [31:0] result);
    @(negedge clk_i);
    mem_valid_i = 1'b1; mem_wr_i = 1'b0; mem_size_i = size; load_sign_i = sign;
    addr_i = addr; data_addr_ok_i = 1'b1;
    #1 checkOutput("load.issueReq", 32'(data_req_o), 32'd1);
    checkOutput("load.issueStall", 32'(mem_stall_o), 32'd1);
    @(negedge clk_i);
    data_addr_ok_i = 1'b0; data_data_ok_i = 1'b1; data_rdata_i = rdata;
    #1 checkOutput("load.dataStall", 32'(mem_stall_o), 32'd1);
    @(negedge clk_i);
    data_data_ok_i = 1'b0; data_rdata_i = 32'h0;
    #1 checkOutput("load.doneStall", 32'(mem_stall_o), 32'd0);
    result = load_data_o;
    advance_i = 1'b1; mem_valid_i = 1'b0;
    @(negedge clk_i);
    advance_i = 1'b0;
  endtask

  initial begin
    logic [31:0] res;

    idleInputs();
    resetn_i = 1'b0;
    vecs[0]  = '{1'b1, 1'b0, SIZE_WORD, 32'h100, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, SIZE_WORD, 32'h101, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h0};
    vecs[2]  = '{1'b1, 1'b0, SIZE_HALF, 32'h102, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 1'b0, SIZE_HALF, 32'h103, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h0};
    vecs[4]  = '{1'b1, 1'b1, SIZE_BYTE, 32'h103, 32'h1234ABCD, 1'b0, 1'b1, 1'b1, 1'b0, 32'hCDCDCDCD};
    vecs[5]  = '{1'b1, 1'b1, SIZE_HALF, 32'h102, 32'h1234ABCD, 1'b0, 1'b1, 1'b1, 1'b0, 32'hABCDABCD};
    vecs[6]  = '{1'b1, 1'b1, SIZE_WORD, 32'h104, 32'h1234ABCD, 1'b0, 1'b1, 1'b1, 1'b0, 32'h1234ABCD};
    vecs[7]  = '{1'b0, 1'b0, SIZE_WORD, 32'h100, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[8]  = '{1'b1, 1'b0, SIZE_WORD, 32'h100, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[9]  = '{1'b1, 1'b0, SIZE_WORD, 32'h102, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 32'h0};
    vecs[10] = '{1'b1, 1'b1, SIZE_WORD, 32'h106, 32'h1234ABCD, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0};
    vecs[11] = '{1'b1, 1'b0, SIZE_BYTE, 32'h101, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 32'h0};

    repeat (2) @(negedge clk_i);
    checkOutput("reset.req", 32'(data_req_o), 32'd0);
    checkOutput("reset.stall", 32'(mem_stall_o), 32'd0);
    checkOutput("reset.loadData", load_data_o, 32'h0);
    checkOutput("reset.addrErr", 32'(addr_err_o), 32'd0);
    resetn_i = 1'b1;

    // Issue decision in IDLE; inputs are withdrawn before the rising edge.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_i);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("vec%0d.req", i), 32'(data_req_o), 32'(vecs[i].expReq));
      checkOutput($sformatf("vec%0d.stall", i), 32'(mem_stall_o), 32'(vecs[i].expStall));
      checkOutput($sformatf("vec%0d.addrErr", i), 32'(addr_err_o), 32'(vecs[i].expErr));
      if (vecs[i].expReq) begin
        checkOutput($sformatf("vec%0d.addr", i), data_addr_o, vecs[i].addr);
        checkOutput($sformatf("vec%0d.size", i), 32'(data_size_o), 32'(vecs[i].size));
        checkOutput($sformatf("vec%0d.wr", i), 32'(data_wr_o), 32'(vecs[i].wr));
        if (vecs[i].wr)
          checkOutput($sformatf("vec%0d.wdata", i), data_wdata_o, vecs[i].expWdata);
      end
      #1 idleInputs();
    end

    runLoad(32'h100, SIZE_WORD, 1'b0, 32'hDEADBEEF, res);
    checkOutput("lw.result", res, 32'hDEADBEEF);
    runLoad(32'h103, SIZE_BYTE, 1'b1, 32'h80FFFF7F, res);
    checkOutput("lb.result", res, 32'hFFFFFF80);
    runLoad(32'h103, SIZE_BYTE, 1'b0, 32'h80FFFF7F, res);
    checkOutput("lbu.result", res, 32'h00000080);

    // Store with addr_ok held off for 3 cycles; bus fields must come from
    // the captured copy even when the pipeline inputs change.
    @(negedge clk_i);
    mem_valid_i = 1'b1; mem_wr_i = 1'b1; mem_size_i = SIZE_HALF;
    addr_i = 32'h102; store_data_i = 32'h1234ABCD;
    #1 checkOutput("sh.issueReq", 32'(data_req_o), 32'd1);
    checkOutput("sh.issueWdata", data_wdata_o, 32'hABCDABCD);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk_i);
      addr_i = 32'h0F00; store_data_i = 32'h55555555; mem_size_i = SIZE_WORD;
      if (k == 3) data_addr_ok_i = 1'b1;
      #1;
      checkOutput($sformatf("sh.holdReq%0d", k), 32'(data_req_o), 32'd1);
      checkOutput($sformatf("sh.holdWdata%0d", k), data_wdata_o, 32'hABCDABCD);
      checkOutput($sformatf("sh.holdAddr%0d", k), data_addr_o, 32'h102);
      checkOutput($sformatf("sh.holdSize%0d", k), 32'(data_size_o), 32'(SIZE_HALF));
      checkOutput($sformatf("sh.holdWr%0d", k), 32'(data_wr_o), 32'd1);
    end
    @(negedge clk_i);
    data_addr_ok_i = 1'b0; data_data_ok_i = 1'b1; data_rdata_i = 32'h99999999;
    #1 checkOutput("sh.dataReq", 32'(data_req_o), 32'd0);
    checkOutput("sh.dataStall", 32'(mem_stall_o), 32'd1);
    @(negedge clk_i);
    data_data_ok_i = 1'b0;
    #1 checkOutput("sh.doneStall", 32'(mem_stall_o), 32'd0);
    checkOutput("sh.loadDataKept", load_data_o, 32'h00000080);
    idleInputs(); advance_i = 1'b1;
    @(negedge clk_i);
    advance_i = 1'b0;

    // Load sits in DONE for 3 cycles without advance: no re-issue.
    @(negedge clk_i);
    mem_valid_i = 1'b1; mem_size_i = SIZE_WORD; addr_i = 32'h200; data_addr_ok_i = 1'b1;
    @(negedge clk_i);
    data_addr_ok_i = 1'b0; data_data_ok_i = 1'b1; data_rdata_i = 32'hCAFEF00D;
    @(negedge clk_i);
    data_data_ok_i = 1'b0; data_rdata_i = 32'h0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checkOutput($sformatf("done.stall%0d", k), 32'(mem_stall_o), 32'd0);
      checkOutput($sformatf("done.req%0d", k), 32'(data_req_o), 32'd0);
      checkOutput($sformatf("done.data%0d", k), load_data_o, 32'hCAFEF00D);
      @(negedge clk_i);
    end
    mem_valid_i = 1'b0; advance_i = 1'b1;
    @(negedge clk_i);
    advance_i = 1'b0;

    // Flush pulse in DATA: transaction completes, result dropped, DONE skipped.
    @(negedge clk_i);
    mem_valid_i = 1'b1; mem_size_i = SIZE_WORD; addr_i = 32'h300; data_addr_ok_i = 1'b1;
    @(negedge clk_i);
    data_addr_ok_i = 1'b0; flush_i = 1'b1;
    #1 checkOutput("flush.dataStall", 32'(mem_stall_o), 32'd1);
    @(negedge clk_i);
    flush_i = 1'b0; data_data_ok_i = 1'b1; data_rdata_i = 32'h11112222;
    #1 checkOutput("flush.waitStall", 32'(mem_stall_o), 32'd1);
    @(negedge clk_i);
    data_data_ok_i = 1'b0;
    #1 checkOutput("flush.backInIdle", 32'(data_req_o), 32'd1);
    checkOutput("flush.resultDropped", load_data_o, 32'hCAFEF00D);
    #1 idleInputs();

    runLoad(32'h102, SIZE_HALF, 1'b1, 32'hABCD1234, res);
    checkOutput("lh.result", res, 32'hFFFFABCD);

    // Asynchronous reset while waiting in DATA.
    @(negedge clk_i);
    mem_valid_i = 1'b1; mem_size_i = SIZE_WORD; addr_i = 32'h400; data_addr_ok_i = 1'b1;
    @(negedge clk_i);
    data_addr_ok_i = 1'b0;
    #1 checkOutput("rstData.stallBefore", 32'(mem_stall_o), 32'd1);
    resetn_i = 1'b0;
    #1 checkOutput("rstData.req", 32'(data_req_o), 32'd0);
    checkOutput("rstData.stall", 32'(mem_stall_o), 32'd0);
    checkOutput("rstData.loadData", load_data_o, 32'h0);
    @(negedge clk_i);
    idleInputs(); resetn_i = 1'b1;
    @(negedge clk_i);
    data_data_ok_i = 1'b1; data_rdata_i = 32'h77777777;
    @(negedge clk_i);
    data_data_ok_i = 1'b0;
    #1 checkOutput("idle.dataOkIgnored", load_data_o, 32'h0);
    checkOutput("idle.stall", 32'(mem_stall_o), 32'd0);
    mem_valid_i = 1'b1; mem_size_i = SIZE_WORD; addr_i = 32'h400;
    #1 checkOutput("rstData.idleIssue", 32'(data_req_o), 32'd1);
    #1 idleInputs();

    repeat (2) @(negedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
